// File: rtl/noc_local_ni.sv
// Local network interface between a processing element and the L port of router_5p.
// Credit-based flit injection toward the router; buffered ejection with one credit pulse per consumed flit.
module noc_local_ni #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pe_tx_valid,
  output logic       pe_tx_ready,
  input  logic [1:0] pe_tx_dx,
  input  logic [1:0] pe_tx_dy,
  input  logic [3:0] pe_tx_payload,
  output logic [7:0] Data_out,
  output logic       val_out,
  input  logic       ret_in,
  input  logic [7:0] Data_in,
  input  logic       val_in,
  output logic       ret_out,
  output logic       pe_rx_valid,
  input  logic       pe_rx_ready,
  output logic [7:0] pe_rx_data,
  output logic [2:0] credit_cnt,
  output logic       err_credit,
  output logic       err_overflow
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  logic [7:0] tx_mem_r [TX_DEPTH];
  logic [7:0] rx_mem_r [RX_DEPTH];
  logic [TAW:0] tx_wptr_r, tx_rptr_r;
  logic [RAW:0] rx_wptr_r, rx_rptr_r;
  logic [2:0] credit_cnt_r, credit_nxt_s;
  logic       credit_err_s;
  logic [7:0] data_out_r;
  logic       val_out_r, ret_out_r, err_credit_r, err_overflow_r;
  logic       tx_empty_s, tx_full_s, tx_push_s, issue_s;
  logic       rx_empty_s, rx_full_s, rx_pop_s, rx_wr_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
  assign tx_full_s  = (tx_wptr_r[TAW] != tx_rptr_r[TAW]) && (tx_wptr_r[TAW-1:0] == tx_rptr_r[TAW-1:0]);
  assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
  assign rx_full_s  = (rx_wptr_r[RAW] != rx_rptr_r[RAW]) && (rx_wptr_r[RAW-1:0] == rx_rptr_r[RAW-1:0]);

  assign tx_push_s = pe_tx_valid & ~tx_full_s;
  assign issue_s   = ~tx_empty_s & (credit_cnt_r != 3'd0);
  assign rx_pop_s  = ~rx_empty_s & pe_rx_ready;
  assign rx_wr_s   = val_in & (~rx_full_s | rx_pop_s);

  // Credit next-state: issue consumes, ret_in returns, both together cancel.
  always_comb begin
    credit_nxt_s = credit_cnt_r;
    credit_err_s = 1'b0;
    case ({issue_s, ret_in})
      2'b10: credit_nxt_s = credit_cnt_r - 3'd1;
      2'b01: begin
        if (credit_cnt_r == CRED_MAX) begin
          credit_err_s = 1'b1;
        end else begin
          credit_nxt_s = credit_cnt_r + 3'd1;
        end
      end
      default: credit_nxt_s = credit_cnt_r;
    endcase
  end

  // Injection path: TX FIFO pointers, registered flit stage and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_r    <= '0;
      tx_rptr_r    <= '0;
      data_out_r   <= 8'h00;
      val_out_r    <= 1'b0;
      credit_cnt_r <= CRED_MAX;
      err_credit_r <= 1'b0;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wptr_r[TAW-1:0]] <= {pe_tx_dx, pe_tx_dy, pe_tx_payload};
        tx_wptr_r <= tx_wptr_r + 1'b1;
      end
      if (issue_s) begin
        tx_rptr_r <= tx_rptr_r + 1'b1;
      end
      data_out_r   <= issue_s ? tx_mem_r[tx_rptr_r[TAW-1:0]] : 8'h00;
      val_out_r    <= issue_s;
      credit_cnt_r <= credit_nxt_s;
      err_credit_r <= err_credit_r | credit_err_s;
    end
  end

  // Ejection path: RX FIFO, credit return pulse and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_r      <= '0;
      rx_rptr_r      <= '0;
      ret_out_r      <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      if (rx_wr_s) begin
        rx_mem_r[rx_wptr_r[RAW-1:0]] <= Data_in;
        rx_wptr_r <= rx_wptr_r + 1'b1;
      end
      if (rx_pop_s) begin
        rx_rptr_r <= rx_rptr_r + 1'b1;
      end
      ret_out_r      <= rx_pop_s;
      err_overflow_r <= err_overflow_r | (val_in & rx_full_s & ~rx_pop_s);
    end
  end

  assign pe_tx_ready  = ~tx_full_s;
  assign Data_out     = data_out_r;
  assign val_out      = val_out_r;
  assign ret_out      = ret_out_r;
  assign pe_rx_valid  = ~rx_empty_s;
  assign pe_rx_data   = rx_empty_s ? 8'h00 : rx_mem_r[rx_rptr_r[RAW-1:0]];
  assign credit_cnt   = credit_cnt_r;
  assign err_credit   = err_credit_r;
  assign err_overflow = err_overflow_r;

endmodule
